// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types and colour constants for the tile painter
//
// Contents:
//   tile_type_e  : 2-bit tile type (BACKGROUND, FLOOR, GIFT, HOLE)
//   COL_*        : 8-bit palette entries used by the painter
//   pop_state_e  : collect/pop animation FSM states
package tile_pkg;

  typedef enum logic [1:0] {
    BACKGROUND = 2'b00,
    FLOOR      = 2'b01,
    GIFT       = 2'b10,
    HOLE       = 2'b11
  } tile_type_e;

  localparam logic [7:0] COL_TRANSPARENT = 8'hFF;
  localparam logic [7:0] COL_FLOOR       = 8'hA1;
  localparam logic [7:0] COL_GIFT        = 8'hBB;
  localparam logic [7:0] COL_HOLE        = 8'hF1;

  typedef enum logic {
    IDLE = 1'b0,
    POP  = 1'b1
  } pop_state_e;

endpackage

// File: rtl/tile_anim_ctrl.sv
// rtl/tile_anim_ctrl.sv - frame blink counter and gift pop animation FSM
//
// Optional feature macro: TILE_PAINTER_BLINK_EN (gift blinking).
// Ports:
//   clk, resetN   : pixel clock, asynchronous active-low reset
//   startOfFrame  : one-cycle pulse per frame
//   collectReq    : one-cycle pulse starting the pop animation
//   giftVisible   : gift icon may be drawn this frame
//   shrink        : pixels removed from each icon side
//   animBusy      : pop animation running (registered)
//   collectDone   : one-cycle pulse when the pop animation ends
module tile_anim_ctrl
  import tile_pkg::*;
#(
  parameter int BLINK_FRAMES = 16,
  parameter int SHRINK_STEP  = 3,
  parameter int ICON_LO      = 21,
  parameter int ICON_HI      = 39
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       collectReq,
  output logic       giftVisible,
  output logic [4:0] shrink,
  output logic       animBusy,
  output logic       collectDone
);

  localparam logic [5:0] STEP6 = 6'(SHRINK_STEP);
  localparam logic [5:0] HALF6 = 6'((ICON_HI - ICON_LO) / 2);

  pop_state_e state_q;
  logic [4:0] shrink_q;
  logic       done_q;
  logic [5:0] shrink_next;

  // One bit wider so a step past the half-icon size is detected, not wrapped.
  assign shrink_next = {1'b0, shrink_q} + STEP6;

  // A frame pulse arriving with collectReq in IDLE is deliberately not applied.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      shrink_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (collectReq) begin
            state_q  <= POP;
            shrink_q <= '0;
          end
        end
        POP: begin
          if (startOfFrame) begin
            if (shrink_next > HALF6) begin
              state_q  <= IDLE;
              shrink_q <= '0;
              done_q   <= 1'b1;
            end else begin
              shrink_q <= shrink_next[4:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shrink      = shrink_q;
  assign animBusy    = (state_q == POP);
  assign collectDone = done_q;

`ifdef TILE_PAINTER_BLINK_EN
  localparam int FC_W = $clog2(2 * BLINK_FRAMES);

  logic [FC_W-1:0] frame_cnt_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
    end else if (startOfFrame) begin
      if (frame_cnt_q == FC_W'(2 * BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
      end else begin
        frame_cnt_q <= frame_cnt_q + FC_W'(1);
      end
    end
  end

  // The gift stays on screen while it pops, even during the off half.
  assign giftVisible = (frame_cnt_q < FC_W'(BLINK_FRAMES)) || (state_q == POP);
`else
  assign giftVisible = 1'b1;
`endif

endmodule

// File: rtl/tile_painter.sv
// rtl/tile_painter.sv - per-tile pixel painter with gift blink and pop animation
//
// Optional feature macro: TILE_PAINTER_BLINK_EN (gift blinking).
// Ports:
//   clk, resetN     : pixel clock, asynchronous active-low reset
//   startOfFrame    : one-cycle pulse per frame
//   offsetX/offsetY : pixel offset inside the tile (11-bit)
//   tileType        : 00 background, 01 floor, 10 gift, 11 hole
//   collectReq      : one-cycle pulse starting the pop animation
//   drawingRequest  : registered, pixel is to be displayed
//   RGBout          : registered colour
//   animBusy        : pop animation running
//   collectDone     : one-cycle pulse when the pop animation ends
module tile_painter
  import tile_pkg::*;
#(
  parameter int TILE_W       = 80,
  parameter int TILE_H       = 80,
  parameter int FLOOR_LEFT   = 11,
  parameter int FLOOR_RIGHT  = 69,
  parameter int FLOOR_TOP    = 64,
  parameter int FLOOR_BOT    = 74,
  parameter int ICON_LO      = 21,
  parameter int ICON_HI      = 39,
  parameter int BLINK_FRAMES = 16,
  parameter int SHRINK_STEP  = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic [1:0]  tileType,
  input  logic        collectReq,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        animBusy,
  output logic        collectDone
);

  localparam logic [10:0] TW    = 11'(TILE_W);
  localparam logic [10:0] TH    = 11'(TILE_H);
  localparam logic [10:0] FL    = 11'(FLOOR_LEFT);
  localparam logic [10:0] FR    = 11'(FLOOR_RIGHT);
  localparam logic [10:0] FT    = 11'(FLOOR_TOP);
  localparam logic [10:0] FB    = 11'(FLOOR_BOT);
  localparam logic [10:0] MASK0 = 11'(FLOOR_TOP - 3);
  localparam logic [10:0] MASK1 = 11'(FLOOR_TOP - 1);
  localparam logic [10:0] BGLN  = 11'(FLOOR_TOP - 2);
  localparam logic [10:0] IL    = 11'(ICON_LO);
  localparam logic [10:0] IH    = 11'(ICON_HI);

  logic        gift_visible;
  logic [4:0]  shrink;
  tile_type_e  tile_type;
  logic        x_in_floor;
  logic [10:0] icon_lo;
  logic [10:0] icon_hi;
  logic        in_gift;
  logic        in_hole;
  logic [7:0]  rgb_d,  rgb_q;
  logic        draw_d, draw_q;

  tile_anim_ctrl #(
    .BLINK_FRAMES(BLINK_FRAMES),
    .SHRINK_STEP (SHRINK_STEP),
    .ICON_LO     (ICON_LO),
    .ICON_HI     (ICON_HI)
  ) u_anim (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .collectReq  (collectReq),
    .giftVisible (gift_visible),
    .shrink      (shrink),
    .animBusy    (animBusy),
    .collectDone (collectDone)
  );

  assign tile_type  = tile_type_e'(tileType);
  assign x_in_floor = (offsetX >= FL) && (offsetX <= FR);
  assign icon_lo    = IL + 11'(shrink);
  assign icon_hi    = IH - 11'(shrink);
  assign in_gift    = (offsetX >= icon_lo) && (offsetX <= icon_hi) &&
                      (offsetY >= icon_lo) && (offsetY <= icon_hi);
  assign in_hole    = (offsetX >= IL) && (offsetX <= IH) &&
                      (offsetY >= IL) && (offsetY <= IH);

  // First matching rule wins.
  always_comb begin
    rgb_d  = COL_TRANSPARENT;
    draw_d = 1'b0;
    if (offsetX >= TW || offsetY >= TH) begin
      rgb_d  = COL_TRANSPARENT;
      draw_d = 1'b0;
    end else if (tile_type != BACKGROUND && offsetY >= FT && offsetY <= FB && x_in_floor) begin
      rgb_d  = COL_FLOOR;
      draw_d = 1'b1;
    end else if (tile_type != BACKGROUND && offsetY >= MASK0 && offsetY <= MASK1 && x_in_floor) begin
      rgb_d  = COL_TRANSPARENT;
      draw_d = 1'b1;
    end else if (tile_type == BACKGROUND && offsetY == BGLN && x_in_floor) begin
      rgb_d  = COL_TRANSPARENT;
      draw_d = 1'b1;
    end else if (tile_type == GIFT && in_gift && gift_visible) begin
      rgb_d  = COL_GIFT;
      draw_d = 1'b1;
    end else if (tile_type == HOLE && in_hole) begin
      rgb_d  = COL_HOLE;
      draw_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q  <= 8'h00;
      draw_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      draw_q <= draw_d;
    end
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = draw_q;

endmodule

// File: doc/tile_painter.md
# tile_painter

Parametrised per-tile pixel painter for the VGA tile layer, the next generation of the fixed-geometry tile drawer. From the pixel's offset inside its tile and the tile type, it produces a registered colour and drawing request for the object mux. It adds two features: gift-tile blinking driven by frame pulses, and a gift-collection "pop" animation (shrinking icon) with a completion pulse that game logic uses to retire the gift.

## Interface
Parameters:
- TILE_W, 80: tile width in pixels; offsetX ≥ TILE_W is never drawn.
- TILE_H, 80: tile height in pixels; offsetY ≥ TILE_H is never drawn.
- FLOOR_LEFT, 11 / FLOOR_RIGHT, 69: inclusive X span of the floor bar and mask bands.
- FLOOR_TOP, 64 / FLOOR_BOT, 74: inclusive Y span of the floor bar.
- ICON_LO, 21 / ICON_HI, 39: inclusive X and Y span of the gift/hole icon square.
- BLINK_FRAMES, 16: frames on, then frames off, per blink period.
- SHRINK_STEP, 3: pixels removed from each icon side per frame during pop.

Ports:
- clk  in  1: pixel clock.
- resetN  in  1: reset, asynchronous, active-low.
- startOfFrame  in  1: one-cycle pulse, once per frame.
- offsetX  in  11: pixel X offset inside the tile.
- offsetY  in  11: pixel Y offset inside the tile.
- tileType  in  2: 00 background, 01 floor, 10 gift, 11 hole.
- collectReq  in  1: one-cycle pulse that starts the pop animation.
- drawingRequest  out  1: registered; pixel is to be displayed.
- RGBout  out  8: registered colour.
- animBusy  out  1: high while the pop animation runs.
- collectDone  out  1: one-cycle pulse when the pop animation finishes.

## Operation
Pixel priority, first match wins; x = offsetX, y = offsetY, xr = FLOOR_LEFT ≤ x ≤ FLOOR_RIGHT:
1. x ≥ TILE_W or y ≥ TILE_H: colour 0xFF, no draw.
2. Type ≠ background, FLOOR_TOP ≤ y ≤ FLOOR_BOT, xr: colour 0xA1 (floor), draw.
3. Type ≠ background, FLOOR_TOP−3 ≤ y ≤ FLOOR_TOP−1, xr: colour 0xFF, draw (mask band).
4. Type background, y = FLOOR_TOP−2, xr: colour 0xFF, draw.
5. Gift, with lo = ICON_LO+shrink and hi = ICON_HI−shrink, lo ≤ x ≤ hi and lo ≤ y ≤ hi, and giftVisible: colour 0xBB, draw.
6. Hole, ICON_LO ≤ x,y ≤ ICON_HI: colour 0xF1, draw.
7. Otherwise: colour 0xFF, no draw.

Blink counter:
- frameCnt counts startOfFrame pulses from 0 to 2·BLINK_FRAMES−1, then wraps to 0.
- blinkOn = (frameCnt < BLINK_FRAMES).
- giftVisible = blinkOn OR animBusy; the gift is forced visible during pop.

Collect FSM, states IDLE and POP:
- IDLE: collectReq → POP, shrink = 0. collectReq and startOfFrame in the same cycle → POP with shrink 0; that frame pulse is not applied.
- POP, on startOfFrame:
  - If shrink + SHRINK_STEP > (ICON_HI−ICON_LO)/2 (integer), go to IDLE, set shrink = 0, and pulse collectDone next cycle.
  - Otherwise shrink += SHRINK_STEP.
- POP: collectReq is ignored.
- animBusy = (state == POP), registered.
- The animation is global: all gift tiles on screen pop together. Game logic must change the tile type on collectDone.

Arithmetic:
- Comparisons are unsigned 11-bit.
- shrink is 5 bits. Parameters must satisfy SHRINK_STEP ≤ (ICON_HI−ICON_LO)/2 < 32.

## Timing
- Latency is 1 cycle: RGBout and drawingRequest reflect the inputs sampled on the previous clk edge.
- Reset values: RGBout 0x00, drawingRequest 0, animBusy 0, collectDone 0, frameCnt 0, shrink 0, state IDLE.
- Reset mid-POP aborts the animation; no collectDone is issued.
- A shrink or blink change takes effect on the cycle after the startOfFrame edge, so it is stable for the whole visible frame.
- collectDone is high for exactly one cycle, coincident with animBusy falling.

## Configuration
- TILE_PAINTER_BLINK_EN defined: gift blinking as above.
- TILE_PAINTER_BLINK_EN undefined:
  - frameCnt is not built.
  - giftVisible is constant 1.
  - The pop animation is unaffected.

## Structure
- Package tile_pkg holds:
  - the tile-type enum (BACKGROUND, FLOOR, GIFT, HOLE);
  - colour constants TRANSPARENT 0xFF, FLOOR 0xA1, GIFT 0xBB, HOLE 0xF1;
  - the pop-FSM state enum.
- Sub-module tile_anim_ctrl holds frameCnt, the collect FSM and shrink. Its outputs are giftVisible, shrink, animBusy and collectDone.
- The top level contains the priority painter and the output registers.

## Test plan
- Reset with no events: tileType=01, (x,y)=(40,70) → next cycle RGB 0xA1, draw 1. (40,62) → 0xFF, draw 1. (5,70) → draw 0.
- tileType=00, (40,62) → 0xFF, draw 1. (40,63) → draw 0. (90,10) with any type → draw 0.
- tileType=10, (30,30) → 0xBB, draw 1. After 16 startOfFrame pulses → draw 0. After 32 → draw 1 again (wrap).
- collectReq, then probe (21,21) → draw 1 until the 1st frame pulse, then draw 0. (24,24) → draw 1, draw 0 after the 2nd pulse. collectDone pulses once after the 4th pulse, animBusy falls with it.
- collectReq during POP → ignored (still 4 pulses total). Reset asserted after 2 pulses → animBusy 0, no collectDone.
- Build without TILE_PAINTER_BLINK_EN: gift at (30,30) stays drawn across 40 frame pulses.
